// File: rtl/lc3_pkg.sv
// Shared LC-3 types and helpers for the branch resolution path.
// Holds the BR sequencer state encoding and offset sign extension.
package lc3_pkg;

    localparam logic [3:0] OP_BR = 4'b0000;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_EVAL,
        BR_TAKEN,
        BR_DONE
    } br_state_t;

    function automatic logic [15:0] sext9(input logic [8:0] off);
        return {{7{off[8]}}, off};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for branch statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // next count: step only when below the ceiling
    always_comb begin
        q_d = q_q;
        if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    // count register with synchronous clear
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/branch_unit.sv
// LC-3 BR resolution: BEN flag, start/done sequencer, target and ld_pc.
// Taken/not-taken statistics kept in two saturating counters.
module branch_unit
    import lc3_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [15:0]      IR,
    input  logic [15:0]      PC,
    input  logic             n,
    input  logic             z,
    input  logic             p,
    input  logic             LD_BEN,
    input  logic             start,
    output logic             ben,
    output logic             busy,
    output logic             done,
    output logic             ld_pc,
    output logic [15:0]      target_pc,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    br_state_t   state_q, state_d;
    logic [11:0] ir_q, ir_d;
    logic [15:0] pc_q, pc_d;
    logic        ben_q, ben_d;
    logic [15:0] tgt_q, tgt_d;
    logic        inc_taken;
    logic        inc_ntaken;
    logic [2:0]  nzp;
    logic        cond;

    // opcode bits are decoded by the ISDU, not here
    logic unused_opcode;
    assign unused_opcode = &{1'b0, IR[15:12]};

    assign nzp  = {n, z, p};
    // captured mask against live flags, as seen in EVAL
    assign cond = |(ir_q[11:9] & nzp);

    // sequencer next-state, capture, ben and target updates
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        ben_d      = ben_q;
        tgt_d      = tgt_q;
        inc_taken  = 1'b0;
        inc_ntaken = 1'b0;
        unique case (state_q)
            BR_IDLE: begin
                if (start) begin
                    state_d = BR_EVAL;
                    ir_d    = IR[11:0];
                    pc_d    = PC;
                end else if (LD_BEN) begin
                    ben_d = |(IR[11:9] & nzp);
                end
            end
            BR_EVAL: begin
                ben_d = cond;
                tgt_d = pc_q + sext9(ir_q[8:0]);
                if (cond) begin
                    state_d = BR_TAKEN;
                end else begin
                    state_d    = BR_DONE;
                    inc_ntaken = 1'b1;
                end
            end
            BR_TAKEN: begin
                inc_taken = 1'b1;
                state_d   = BR_DONE;
            end
            BR_DONE: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    // state and capture registers, cleared by reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= BR_IDLE;
            ir_q    <= '0;
            pc_q    <= '0;
            ben_q   <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            ben_q   <= ben_d;
            tgt_q   <= tgt_d;
        end
    end

    assign busy      = (state_q != BR_IDLE);
    assign ld_pc     = (state_q == BR_TAKEN);
    assign done      = (state_q == BR_DONE);
    assign ben       = ben_q;
    assign target_pc = tgt_q;

    sat_counter #(.W(CNT_W)) u_taken (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (inc_taken),
        .q     (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ntaken (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (inc_ntaken),
        .q     (ntaken_cnt)
    );

endmodule
